// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the data stage,
// with a DM grant streak limit, branch-flush discard of in-flight fetches, and a bus watchdog.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [WW-1:0] wd_cnt, wd_cnt_nxt;
  logic          discard, discard_nxt;
  logic          mem_req_nxt, mem_we_nxt, bus_err_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          if_elig, streak_full, wd_expired;

  // Completion and stall outputs are the only combinational paths.
  assign if_done  = (state == BUSY_IF) & mem_ack & ~discard & ~if_flush;
  assign dm_done  = (state == BUSY_DM) & mem_ack;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  assign if_elig     = if_req & ~if_flush;
  assign streak_full = (streak == SW'(MAX_STREAK));
  assign wd_expired  = (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      wd_cnt    <= '0;
      discard   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      wd_cnt    <= wd_cnt_nxt;
      discard   <= discard_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      bus_err   <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    streak_nxt    = streak;
    wd_cnt_nxt    = wd_cnt;
    discard_nxt   = discard;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    bus_err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        wd_cnt_nxt  = '0;
        discard_nxt = 1'b0;
        // DM has priority unless IF has already been passed over MAX_STREAK times.
        if (dm_req && !(if_elig && streak_full)) begin
          state_nxt     = BUSY_DM;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = dm_we;
          mem_addr_nxt  = dm_addr;
          mem_wdata_nxt = dm_wdata;
          if (if_elig) streak_nxt = streak_full ? streak : streak + SW'(1);
          else         streak_nxt = '0;
        end else if (if_elig) begin
          state_nxt    = BUSY_IF;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = if_addr;
          streak_nxt   = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack || wd_expired) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          discard_nxt = 1'b0;
          bus_err_nxt = ~mem_ack;
          wd_cnt_nxt  = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + WW'(1);
          if (state == BUSY_IF && if_flush) discard_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for streak limiting, flush discard, watchdog abort and mid-access reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_if_done;
    logic        e_dm_done;
    logic        e_if_stall;
    logic        e_dm_stall;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    int busy_cnt;
    logic exp_if;

    // Single fetch, then simultaneous IF + DM store, then IF after bubble, then stray ack.
    vecs[0] = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0,    32'h0};
    vecs[1] = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        1, 32'h11110001, 1, 0, 0, 0, 1, 0, 32'h100,  32'h0};
    vecs[2] = '{1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 32'h0,        0, 0, 1, 1, 0, 0, 32'h0,    32'h0};
    vecs[3] = '{1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 32'h0,        0, 0, 1, 1, 1, 1, 32'h2000, 32'hDEADBEEF};
    vecs[4] = '{1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 1, 32'hAAAA5555, 0, 1, 1, 0, 1, 1, 32'h2000, 32'hDEADBEEF};
    vecs[5] = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0,    32'h0};
    vecs[6] = '{1, 32'h104, 0, 0, 32'h0,    32'h0,        1, 32'h22220002, 1, 0, 0, 0, 1, 0, 32'h104,  32'h0};
    vecs[7] = '{0, 32'h0,   0, 0, 32'h0,    32'h0,        1, 32'h33,       0, 0, 0, 0, 0, 0, 32'h0,    32'h0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);
    chk("rst_bus_err",   32'(bus_err),   32'h0);
    chk("rst_if_done",   32'(if_done),   32'h0);
    chk("rst_dm_done",   32'(dm_done),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
      #1;
      chk($sformatf("v%0d_if_done", i),  32'(if_done),  32'(vecs[i].e_if_done));
      chk($sformatf("v%0d_dm_done", i),  32'(dm_done),  32'(vecs[i].e_dm_done));
      chk($sformatf("v%0d_if_stall", i), 32'(if_stall), 32'(vecs[i].e_if_stall));
      chk($sformatf("v%0d_dm_stall", i), 32'(dm_stall), 32'(vecs[i].e_dm_stall));
      chk($sformatf("v%0d_mem_req", i),  32'(mem_req),  32'(vecs[i].e_mem_req));
      chk($sformatf("v%0d_mem_we", i),   32'(mem_we),   32'(vecs[i].e_mem_we));
      if (vecs[i].e_mem_req) chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      if (vecs[i].e_mem_we)  chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      if (vecs[i].e_if_done) chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].mem_rdata);
      if (vecs[i].e_dm_done) chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].mem_rdata);
    end

    // DM held with IF pending: four DM grants, then IF, then DM again (streak cleared).
    for (int g = 0; g < 6; g++) begin
      exp_if = (g == 4);
      @(negedge clk);
      mem_ack = 1'b0;
      if_req = 1'b1; if_addr = 32'h500;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'h0000_0C0D;
      #1 chk($sformatf("streak%0d_idle", g), 32'(mem_req), 32'h0);
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'(g);
      #1;
      chk($sformatf("streak%0d_addr", g), mem_addr, exp_if ? 32'h500 : 32'h3000);
      chk($sformatf("streak%0d_if_done", g), 32'(if_done), 32'(exp_if));
      chk($sformatf("streak%0d_dm_done", g), 32'(dm_done), 32'(!exp_if));
    end
    @(negedge clk);
    idle_inputs();
    #1 chk("streak_end_idle", 32'(mem_req), 32'h0);

    // Flush two cycles into a five-cycle fetch discards its completion.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk); #1;
    chk("flush_busy_req",  32'(mem_req), 32'h1);
    chk("flush_busy_addr", mem_addr,     32'h600);
    @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("flush_ack_if_done", 32'(if_done), 32'h0);
    chk("flush_ack_mem_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h700;
    #1 chk("flush_after_idle", 32'(mem_req), 32'h0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h7777_0000;
    #1;
    chk("refetch_if_done", 32'(if_done), 32'h1);
    chk("refetch_addr",    mem_addr,     32'h700);
    chk("refetch_rdata",   if_rdata,     32'h7777_0000);
    @(negedge clk);
    mem_ack = 1'b0; if_addr = 32'h800;
    @(negedge clk);
    mem_ack = 1'b1; if_flush = 1'b1;
    #1;
    chk("flush_on_ack_done",  32'(if_done),  32'h0);
    chk("flush_on_ack_stall", 32'(if_stall), 32'h1);
    @(negedge clk);
    idle_inputs();
    #1 chk("flush_on_ack_idle", 32'(mem_req), 32'h0);

    // Watchdog: load never acked for 64 BUSY cycles, aborted, then re-granted.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
    busy_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); #1;
      if (mem_req && !bus_err && dm_stall && !dm_done) busy_cnt++;
    end
    chk("wd_busy_cycles", 32'(busy_cnt), 32'd64);
    @(negedge clk); #1;
    chk("wd_abort_req",   32'(mem_req),  32'h0);
    chk("wd_bus_err",     32'(bus_err),  32'h1);
    chk("wd_dm_stall",    32'(dm_stall), 32'h1);
    chk("wd_no_done",     32'(dm_done),  32'h0);
    @(negedge clk); #1;
    chk("wd_regrant_req", 32'(mem_req),  32'h1);
    chk("wd_err_pulse",   32'(bus_err),  32'h0);
    chk("wd_regrant_addr", mem_addr,     32'h4000);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    #1;
    chk("wd_final_done",  32'(dm_done),  32'h1);
    chk("wd_final_rdata", dm_rdata,      32'h5A5A_5A5A);
    @(negedge clk);
    idle_inputs();

    // Reset during BUSY_DM drops everything immediately.
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h6000; dm_wdata = 32'h77;
    @(negedge clk); #1;
    chk("rstmid_busy", 32'(mem_req), 32'h1);
    mem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_req",   32'(mem_req), 32'h0);
    chk("rstmid_mem_we",    32'(mem_we),  32'h0);
    chk("rstmid_mem_addr",  mem_addr,     32'h0);
    chk("rstmid_mem_wdata", mem_wdata,    32'h0);
    chk("rstmid_bus_err",   32'(bus_err), 32'h0);
    chk("rstmid_dm_done",   32'(dm_done), 32'h0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_idle", 32'(mem_req), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM, driven by the decoded MemRead/MemWrite controls). It grants one transaction at a time, drives the memory-side handshake, and returns combinational stall/done signals so the hazard logic can freeze the affected stages. It also handles branch-flush discard of an in-flight fetch and a bus watchdog.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `MAX_STREAK`, 4: consecutive MEM grants allowed while IF waits; then IF wins the next arbitration.
- `TIMEOUT`, 64: BUSY cycles without `mem_ack` before abort.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  fetch request; level, held until `if_done`/flush.
- `if_addr`  in  AW  fetch address; sampled at grant.
- `if_flush`  in  1  branch taken; discard pending/in-flight fetch.
- `dm_req`  in  1  data request (MemRead|MemWrite); level.
- `dm_we`  in  1  1 = store, 0 = load; sampled at grant.
- `dm_addr`  in  AW  data address; sampled at grant.
- `dm_wdata`  in  DW  store data; sampled at grant.
- `if_done`  out  1  fetch complete this cycle (combinational).
- `if_rdata`  out  DW  instruction word; valid with `if_done`.
- `if_stall`  out  1  `if_req & ~if_done`.
- `dm_done`  out  1  data access complete this cycle (combinational).
- `dm_rdata`  out  DW  load data; valid with `dm_done` when load.
- `dm_stall`  out  1  `dm_req & ~dm_done`.
- `mem_req`  out  1  registered; high for whole BUSY phase.
- `mem_we`  out  1  registered write enable.
- `mem_addr`  out  AW  registered address.
- `mem_wdata`  out  DW  registered write data.
- `mem_ack`  in  1  memory completion, single-cycle pulse.
- `mem_rdata`  in  DW  read data, valid with `mem_ack`.
- `bus_err`  out  1  registered one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, BUSY_IF, BUSY_DM. Reset: IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `bus_err`, streak counter, watchdog counter, discard flag all 0.
- IDLE arbitration (at edge): eligible IF = `if_req & ~if_flush`. Both eligible: DM wins unless streak == MAX_STREAK, then IF. Single eligible: grant it. None: stay.
- Grant: latch address/we/wdata into `mem_*` (IF grant forces `mem_we`=0), `mem_req`=1, watchdog cleared.
- Streak: DM grant while eligible IF pending -> +1 (saturate at MAX_STREAK); any IF grant -> 0; DM grant with no IF pending -> 0.
- BUSY_x with `mem_ack`: `x_done`=1 same cycle, `x_rdata`=`mem_rdata` passthrough; next state IDLE, `mem_req`=0, `mem_we`=0.
- Flush: `if_flush` in BUSY_IF (or earlier in that BUSY_IF phase) sets discard; on ack `if_done` suppressed; discard cleared on leaving BUSY_IF. Flush coincident with ack: `if_done` suppressed.
- Watchdog: counts BUSY cycles; at TIMEOUT with no ack -> IDLE, `bus_err` pulse next cycle, no done; requester stays stalled and is re-arbitrated.
- `mem_ack` in IDLE: ignored.
- `if_done`/`dm_done` never both high; `done` only for the granted requester.

## Timing
- Minimum access: request seen in IDLE cycle N, `mem_req` high N+1, ack earliest N+1 -> `done` in N+1; requester advances at end of N+1.
- One IDLE cycle between back-to-back transactions (bubble); sustained throughput = 1 access per (memory latency + 1) cycles.
- Stall outputs combinational from `*_req`, state and `mem_ack`; no other combinational input-to-output path.
- Reset asserted mid-transaction: immediate IDLE, `mem_req` drops asynchronously; no done.

## Test plan
- Single fetch, memory acks 1st BUSY cycle: `if_req`@0, addr 0x100 -> `mem_req`@1 with `mem_addr`=0x100, `if_done`@1, `if_rdata`=`mem_rdata`, `if_stall` 1@0, 0@1.
- Simultaneous `if_req`+`dm_req` (store 0xDEADBEEF to 0x2000) -> DM first (`mem_we`=1), IF granted after ack+1 IDLE cycle.
- DM held high continuously with IF pending, MAX_STREAK=4 -> 4 DM grants, 5th grant IF, streak reset.
- `if_flush` 2 cycles into a 5-cycle fetch -> no `if_done` on ack, state IDLE next, subsequent fetch completes normally; flush on ack cycle also suppresses.
- No ack, TIMEOUT=64 -> after 64 BUSY cycles IDLE, `bus_err` single pulse, `dm_stall` held, re-granted.
- `rst_n` low during BUSY_DM -> `mem_req`=0 immediately, all outputs reset values, no `dm_done`.
